clk_sel_ctrl: RTL and testbench

CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

---
 rtl/clk_sel_ctrl.sv | 120 ++++++++++++
 tb/tb_clk_sel_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
// Glitch-safe 4:1 clock-mux select sequencer: moves sel_o one bit at a time (LSB first),
// holding each step for SETTLE_CYCLES. Define CLK_SEL_CTRL_SWCNT_EN to enable switch_count_o.
module clk_sel_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [1:0]  RESET_SEL     = 2'b00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    input  logic [1:0] req_sel_i,
    output logic       req_ready_o,
    output logic [1:0] sel_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] switch_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE_LSB,
        SETTLE_MSB,
        DONE
    } state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_nxt;
    logic [1:0] sel_q, sel_nxt;
    logic [1:0] target_q, target_nxt;
    logic [7:0] cnt_q, cnt_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= RESET_SEL;
            target_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_nxt;
            sel_q    <= sel_nxt;
            target_q <= target_nxt;
            cnt_q    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        sel_nxt    = sel_q;
        target_nxt = target_q;
        cnt_nxt    = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    target_nxt = req_sel_i;
                    if (req_sel_i[0] != sel_q[0]) begin
                        sel_nxt[0] = req_sel_i[0];
                        cnt_nxt    = RELOAD;
                        state_nxt  = SETTLE_LSB;
                    end else if (req_sel_i[1] != sel_q[1]) begin
                        sel_nxt[1] = req_sel_i[1];
                        cnt_nxt    = RELOAD;
                        state_nxt  = SETTLE_MSB;
                    end else begin
                        state_nxt  = DONE;
                    end
                end
            end
            SETTLE_LSB: begin
                if (cnt_q == '0) begin
                    // MSB may only move once the LSB step has fully settled
                    if (target_q[1] != sel_q[1]) begin
                        sel_nxt[1] = target_q[1];
                        cnt_nxt    = RELOAD;
                        state_nxt  = SETTLE_MSB;
                    end else begin
                        state_nxt  = DONE;
                    end
                end else begin
                    cnt_nxt = cnt_q - 8'd1;
                end
            end
            SETTLE_MSB: begin
                if (cnt_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sel_o       = sel_q;
    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);

`ifdef CLK_SEL_CTRL_SWCNT_EN
    logic [7:0] swcnt_q;

    // Entering DONE from a settle state means sel_o actually moved
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            swcnt_q <= '0;
        end else if (state_nxt == DONE && state_q != IDLE) begin
            swcnt_q <= swcnt_q + 8'd1;
        end
    end

    assign switch_count_o = swcnt_q;
`else
    assign switch_count_o = 8'h00;
`endif

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Directed bench for clk_sel_ctrl: table of select requests plus hand-written
// corner sequences (held request while busy, mid-sequence reset, counter wrap).
module tb_clk_sel_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_valid_i = 1'b0;
    logic [1:0] req_sel_i = 2'b00;
    logic       req_ready_o;
    logic [1:0] sel_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] switch_count_o;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_cnt = 8'h00;

    clk_sel_ctrl #(.SETTLE_CYCLES(8), .RESET_SEL(2'b00)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_sel_i      (req_sel_i),
        .req_ready_o    (req_ready_o),
        .sel_o          (sel_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .switch_count_o (switch_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] req;
        int         lat;
        logic [1:0] mid;
        logic [1:0] at9;
        logic [1:0] fin;
        logic       chg;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_swcnt();
`ifdef CLK_SEL_CTRL_SWCNT_EN
        return exp_cnt;
`else
        return 8'h00;
`endif
    endfunction

    task automatic do_req(input logic [1:0] req, input int lat, input logic [1:0] mid,
                          input logic [1:0] at9, input logic [1:0] fin, input logic chg);
        int         cyc;
        logic [1:0] prev;
        logic       bad;
        check("ready_idle", req_ready_o, 1);
        prev        = sel_o;
        req_valid_i = 1'b1;
        req_sel_i   = req;
        step();
        req_valid_i = 1'b0;
        req_sel_i   = 2'b00;
        cyc = 1;
        bad = 1'b0;
        check("sel_first", sel_o, mid);
        while (!done_o && cyc < 64) begin
            if (lat == 17 && cyc == 9) check("sel_at9", sel_o, at9);
            if (!busy_o) bad = 1'b1;
            if ($countones(sel_o ^ prev) > 1) bad = 1'b1;
            prev = sel_o;
            step();
            cyc++;
        end
        if ($countones(sel_o ^ prev) > 1) bad = 1'b1;
        check("latency", cyc, lat);
        check("sel_final", sel_o, fin);
        check("one_bit_steps", bad, 0);
        check("ready_in_done", req_ready_o, 0);
        if (chg) exp_cnt++;
        check("switch_count", switch_count_o, exp_swcnt());
        step();
        check("done_width", done_o, 0);
        check("ready_back", req_ready_o, 1);
    endtask

    initial begin
        int         cyc;
        logic       bad;
        logic [1:0] r;

        //           req    lat mid    at9    fin    chg
        vecs[0] = '{2'b01,  9, 2'b01, 2'b01, 2'b01, 1'b1};
        vecs[1] = '{2'b01,  1, 2'b01, 2'b01, 2'b01, 1'b0};
        vecs[2] = '{2'b10, 17, 2'b00, 2'b10, 2'b10, 1'b1};
        vecs[3] = '{2'b10,  1, 2'b10, 2'b10, 2'b10, 1'b0};
        vecs[4] = '{2'b11,  9, 2'b11, 2'b11, 2'b11, 1'b1};
        vecs[5] = '{2'b01,  9, 2'b01, 2'b01, 2'b01, 1'b1};
        vecs[6] = '{2'b00,  9, 2'b00, 2'b00, 2'b00, 1'b1};
        vecs[7] = '{2'b11, 17, 2'b01, 2'b11, 2'b11, 1'b1};
        vecs[8] = '{2'b00, 17, 2'b10, 2'b00, 2'b00, 1'b1};

        step();
        step();
        rst_i = 1'b0;
        check("rst_sel", sel_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ready", req_ready_o, 1);
        check("rst_count", switch_count_o, 0);

        for (int i = 0; i < 9; i++)
            do_req(vecs[i].req, vecs[i].lat, vecs[i].mid, vecs[i].at9, vecs[i].fin, vecs[i].chg);

        // Request held valid while busy; new select only taken after DONE.
        req_valid_i = 1'b1;
        req_sel_i   = 2'b01;
        step();
        req_sel_i = 2'b11;
        cyc = 1;
        bad = 1'b0;
        while (!done_o && cyc < 64) begin
            if (sel_o == 2'b11) bad = 1'b1;
            step();
            cyc++;
        end
        check("held_latency", cyc, 9);
        check("held_ignored", bad, 0);
        check("held_sel", sel_o, 1);
        check("held_ready_done", req_ready_o, 0);
        exp_cnt++;
        check("held_count", switch_count_o, exp_swcnt());
        step();
        check("held_ready_idle", req_ready_o, 1);
        check("held_busy_idle", busy_o, 0);
        step();
        req_valid_i = 1'b0;
        req_sel_i   = 2'b00;
        check("held_accept_busy", busy_o, 1);
        check("held_accept_sel", sel_o, 3);
        cyc = 1;
        while (!done_o && cyc < 64) begin
            step();
            cyc++;
        end
        check("held2_latency", cyc, 9);
        check("held2_sel", sel_o, 3);
        exp_cnt++;
        check("held2_count", switch_count_o, exp_swcnt());
        step();

        // Reset at 5th settle cycle of 00 -> 11.
        do_req(2'b00, 17, 2'b10, 2'b00, 2'b00, 1'b1);
        req_valid_i = 1'b1;
        req_sel_i   = 2'b11;
        step();
        req_valid_i = 1'b0;
        req_sel_i   = 2'b00;
        for (int k = 0; k < 4; k++) step();
        check("abort_pre_sel", sel_o, 1);
        rst_i = 1'b1;
        step();
        rst_i   = 1'b0;
        exp_cnt = 8'h00;
        check("abort_sel", sel_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_done", done_o, 0);
        check("abort_count", switch_count_o, 0);
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done_o || sel_o != 2'b00) bad = 1'b1;
            step();
        end
        check("abort_quiet", bad, 0);

        // 256 alternating switches: counter wraps back to zero.
        for (int i = 0; i < 256; i++) begin
            r = (i % 2 == 0) ? 2'b01 : 2'b00;
            do_req(r, 9, r, r, r, 1'b1);
        end
        check("wrap_count", switch_count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
